// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage data-memory access unit.
//
// Holds a word-organised data memory and performs byte/halfword/word loads
// (sign- or zero-extended) and read-modify-write stores. A programmable number
// of wait states models slow memory: o_stall holds the upstream pipeline while
// an access is in flight. Write-back control fields pass straight through to
// the mem_wb register.
//
// Optional feature: define MEM_ACCESS_DEBUG_PORT_EN to add a side-effect-free
// combinational debug read port (i_debug_addr / o_debug_data).
//
// Ports:
//   i_clk, i_reset       clock, synchronous active-high reset
//   i_enable             advance enable; low freezes FSM, counter and outputs
//   i_mem_rd, i_mem_wr   load / store request (both high = store)
//   i_size, i_unsigned   00 byte, 01 half, 1x word; zero-extend loads when set
//   i_addr, i_wr_data    byte address (ALU result), store data
//   i_wb, i_mem_to_reg,
//   i_addr_wr            pass-through to mem_wb
//   o_mem_result         extended load data
//   o_stall              hold upstream stages
//   o_misaligned         misaligned request flag
//   o_wb, o_mem_to_reg,
//   o_alu_result,
//   o_addr_wr            combinational pass-through
module mem_access_unit #(
  parameter int unsigned BUS_SIZE       = 32,
  parameter int unsigned DATA_ADDR_SIZE = 8,
  parameter int unsigned REG_ADDR_SIZE  = 5,
  parameter int unsigned WAIT_STATES    = 2
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic                      i_enable,
  input  logic                      i_mem_rd,
  input  logic                      i_mem_wr,
  input  logic [1:0]                i_size,
  input  logic                      i_unsigned,
  input  logic [BUS_SIZE-1:0]       i_addr,
  input  logic [BUS_SIZE-1:0]       i_wr_data,
  input  logic                      i_wb,
  input  logic                      i_mem_to_reg,
  input  logic [REG_ADDR_SIZE-1:0]  i_addr_wr,
  output logic [BUS_SIZE-1:0]       o_mem_result,
  output logic                      o_stall,
  output logic                      o_misaligned,
  output logic                      o_wb,
  output logic                      o_mem_to_reg,
  output logic [BUS_SIZE-1:0]       o_alu_result,
  output logic [REG_ADDR_SIZE-1:0]  o_addr_wr
`ifdef MEM_ACCESS_DEBUG_PORT_EN
  ,
  input  logic [DATA_ADDR_SIZE-1:0] i_debug_addr,
  output logic [BUS_SIZE-1:0]       o_debug_data
`endif
);

  localparam int unsigned Depth = 2 ** DATA_ADDR_SIZE;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  // Extract and extend the addressed lane(s) of a memory word.
  function automatic logic [BUS_SIZE-1:0] load_extract(input logic [BUS_SIZE-1:0] word,
                                                       input logic [1:0]          lane,
                                                       input logic [1:0]          size,
                                                       input logic                uns);
    logic [7:0]          b;
    logic [15:0]         h;
    logic [BUS_SIZE-1:0] r;
    b = word[{lane, 3'b000} +: 8];
    h = word[{lane[1], 4'b0000} +: 16];
    case (size)
      2'b00:   r = {{(BUS_SIZE - 8){b[7] & ~uns}}, b};
      2'b01:   r = {{(BUS_SIZE - 16){h[15] & ~uns}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  // Merge store data into the addressed lane(s) of the current word.
  function automatic logic [BUS_SIZE-1:0] store_merge(input logic [BUS_SIZE-1:0] word,
                                                      input logic [1:0]          lane,
                                                      input logic [1:0]          size,
                                                      input logic [BUS_SIZE-1:0] data);
    logic [BUS_SIZE-1:0] r;
    r = word;
    case (size)
      2'b00:   r[{lane, 3'b000} +: 8] = data[7:0];
      2'b01:   r[{lane[1], 4'b0000} +: 16] = data[15:0];
      default: r = data;
    endcase
    return r;
  endfunction

  logic                      req;
  logic                      misaligned;
  logic [DATA_ADDR_SIZE-1:0] idx;
  logic [1:0]                lane;

  logic [BUS_SIZE-1:0]       mem_q [Depth];
  logic                      mem_we;
  logic [DATA_ADDR_SIZE-1:0] mem_widx;
  logic [BUS_SIZE-1:0]       mem_wdata;

  assign req        = i_mem_rd | i_mem_wr;
  assign idx        = i_addr[DATA_ADDR_SIZE+1:2];
  assign lane       = i_addr[1:0];
  // Size 2'b10 is treated as a word, hence the test on i_size[1].
  assign misaligned = req & (((i_size == 2'b01) & i_addr[0]) |
                             (i_size[1] & (i_addr[1:0] != 2'b00)));

  assign o_wb         = i_wb;
  assign o_mem_to_reg = i_mem_to_reg;
  assign o_alu_result = i_addr;
  assign o_addr_wr    = i_addr_wr;

  // Contents survive reset; reset only blocks a commit in the same cycle.
  always_ff @(posedge i_clk) begin
    if (!i_reset && mem_we) begin
      mem_q[mem_widx] <= mem_wdata;
    end
  end

  if (WAIT_STATES == 0) begin : g_comb
    assign mem_we       = i_enable & req & ~misaligned & i_mem_wr;
    assign mem_widx     = idx;
    assign mem_wdata    = store_merge(mem_q[idx], lane, i_size, i_wr_data);
    assign o_stall      = 1'b0;
    assign o_misaligned = misaligned;
    assign o_mem_result = (req & ~misaligned & ~i_mem_wr) ?
                          load_extract(mem_q[idx], lane, i_size, i_unsigned) : '0;
  end else begin : g_fsm
    localparam logic [3:0] CntLoad = 4'(WAIT_STATES - 1);

    state_e                    state_q, state_d;
    logic [3:0]                cnt_q, cnt_d;
    logic [BUS_SIZE-1:0]       res_q, res_d;
    logic [DATA_ADDR_SIZE-1:0] idx_q;
    logic [1:0]                lane_q;
    logic [1:0]                size_q;
    logic                      uns_q;
    logic                      wr_q;
    logic [BUS_SIZE-1:0]       data_q;
    logic                      latch;

    assign mem_widx  = idx_q;
    assign mem_wdata = store_merge(mem_q[idx_q], lane_q, size_q, data_q);

    always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      res_d        = res_q;
      latch        = 1'b0;
      mem_we       = 1'b0;
      o_stall      = 1'b0;
      o_misaligned = 1'b0;
      o_mem_result = res_q;
      unique case (state_q)
        StIdle: begin
          if (misaligned) begin
            o_misaligned = 1'b1;
            o_mem_result = '0;
            if (i_enable) begin
              res_d = '0;
            end
          end else if (req) begin
            // The issuing cycle already counts as the first stall cycle.
            o_stall = 1'b1;
            if (i_enable) begin
              latch   = 1'b1;
              cnt_d   = CntLoad;
              state_d = StBusy;
            end
          end
        end
        StBusy: begin
          o_stall = 1'b1;
          if (i_enable) begin
            // Commit when the counter would reach zero so the total stall is
            // WAIT_STATES cycles; with WAIT_STATES=1 BUSY still lasts one cycle.
            if (cnt_q <= 4'd1) begin
              cnt_d   = '0;
              state_d = StDone;
              if (wr_q) begin
                mem_we = 1'b1;
              end else begin
                res_d = load_extract(mem_q[idx_q], lane_q, size_q, uns_q);
              end
            end else begin
              cnt_d = cnt_q - 4'd1;
            end
          end
        end
        StDone: begin
          // Held request is not re-issued: return to IDLE unconditionally.
          if (i_enable) begin
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end

    always_ff @(posedge i_clk) begin
      if (i_reset) begin
        state_q <= StIdle;
        cnt_q   <= '0;
        res_q   <= '0;
        idx_q   <= '0;
        lane_q  <= '0;
        size_q  <= '0;
        uns_q   <= 1'b0;
        wr_q    <= 1'b0;
        data_q  <= '0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        res_q   <= res_d;
        if (latch) begin
          idx_q  <= idx;
          lane_q <= lane;
          size_q <= i_size;
          uns_q  <= i_unsigned;
          wr_q   <= i_mem_wr;
          data_q <= i_wr_data;
        end
      end
    end
  end

`ifdef MEM_ACCESS_DEBUG_PORT_EN
  assign o_debug_data = mem_q[i_debug_addr];
`else
  // Debug read port not built.
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

  localparam int unsigned WS = 2;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_enable;
  logic        i_mem_rd;
  logic        i_mem_wr;
  logic [1:0]  i_size;
  logic        i_unsigned;
  logic [31:0] i_addr;
  logic [31:0] i_wr_data;
  logic        i_wb;
  logic        i_mem_to_reg;
  logic [4:0]  i_addr_wr;
  logic [31:0] o_mem_result;
  logic        o_stall;
  logic        o_misaligned;
  logic        o_wb;
  logic        o_mem_to_reg;
  logic [31:0] o_alu_result;
  logic [4:0]  o_addr_wr;

  mem_access_unit #(
    .BUS_SIZE      (32),
    .DATA_ADDR_SIZE(8),
    .REG_ADDR_SIZE (5),
    .WAIT_STATES   (WS)
  ) dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_enable     (i_enable),
    .i_mem_rd     (i_mem_rd),
    .i_mem_wr     (i_mem_wr),
    .i_size       (i_size),
    .i_unsigned   (i_unsigned),
    .i_addr       (i_addr),
    .i_wr_data    (i_wr_data),
    .i_wb         (i_wb),
    .i_mem_to_reg (i_mem_to_reg),
    .i_addr_wr    (i_addr_wr),
    .o_mem_result (o_mem_result),
    .o_stall      (o_stall),
    .o_misaligned (o_misaligned),
    .o_wb         (o_wb),
    .o_mem_to_reg (o_mem_to_reg),
    .o_alu_result (o_alu_result),
    .o_addr_wr    (o_addr_wr)
  );

  always #5 i_clk = ~i_clk;

  int          n_vec = 0;
  int          n_bad = 0;
  bit          chk_on = 1'b0;
  logic        exp_stall;
  logic        exp_mis;
  logic [31:0] model_res;
  logic [31:0] mem_m [256];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model's expectations.
  always @(negedge i_clk) begin
    if (chk_on) begin
      chk("stall", 32'(o_stall), 32'(exp_stall));
      chk("misaligned", 32'(o_misaligned), 32'(exp_mis));
      chk("mem_result", o_mem_result, model_res);
      chk("wb", 32'(o_wb), 32'(i_wb));
      chk("mem_to_reg", 32'(o_mem_to_reg), 32'(i_mem_to_reg));
      chk("alu_result", o_alu_result, i_addr);
      chk("addr_wr", 32'(o_addr_wr), 32'(i_addr_wr));
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: run did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] m_load(input logic [31:0] w, input int lane,
                                         input logic [1:0] size, input bit uns);
    logic [31:0] v;
    if (size == 2'b00) begin
      v = (w >> (8 * lane)) & 32'hFF;
      if (!uns && v >= 32'h80) v = v | 32'hFFFFFF00;
    end else if (size == 2'b01) begin
      v = (w >> (8 * lane)) & 32'hFFFF;
      if (!uns && v >= 32'h8000) v = v | 32'hFFFF0000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  function automatic logic [31:0] m_store(input logic [31:0] w, input int lane,
                                          input logic [1:0] size, input logic [31:0] d);
    logic [31:0] mask;
    if (size == 2'b00)      mask = 32'hFF << (8 * lane);
    else if (size == 2'b01) mask = 32'hFFFF << (8 * lane);
    else                    mask = 32'hFFFFFFFF;
    return (w & ~mask) | ((d << (8 * lane)) & mask);
  endfunction

  task automatic step();
    @(posedge i_clk);
    #1;
    i_wb         = 1'($urandom);
    i_mem_to_reg = 1'($urandom);
    i_addr_wr    = 5'($urandom);
  endtask

  task automatic drop();
    i_mem_rd  = 1'b0;
    i_mem_wr  = 1'b0;
    exp_stall = 1'b0;
    exp_mis   = 1'b0;
  endtask

  // One complete access starting in IDLE; freeze = enable-low cycles inside BUSY.
  task automatic access(input bit rd, input bit wr, input logic [1:0] size, input bit uns,
                        input logic [31:0] addr, input logic [31:0] wd, input int freeze,
                        input bit lit_en, input logic [31:0] lit);
    bit          mis;
    int          idx;
    int          lane;
    logic [31:0] ld;
    mis  = (size == 2'b01 && addr[0]) || (size[1] && addr[1:0] != 2'b00);
    idx  = int'(addr[9:2]);
    lane = int'(addr[1:0]);
    i_mem_rd = rd; i_mem_wr = wr; i_size = size; i_unsigned = uns;
    i_addr = addr; i_wr_data = wd; i_enable = 1'b1;
    if (!rd && !wr) begin
      drop();
      step();
      return;
    end
    if (mis) begin
      exp_stall = 1'b0;
      exp_mis   = 1'b1;
      model_res = '0;
      step();
      drop();
      return;
    end
    exp_stall = 1'b1;
    exp_mis   = 1'b0;
    step();
    for (int k = 0; k < freeze; k++) begin
      i_enable = 1'b0;
      step();
    end
    i_enable = 1'b1;
    for (int k = 0; k < int'(WS) - 1; k++) step();
    exp_stall = 1'b0;
    if (wr) begin
      mem_m[idx] = m_store(mem_m[idx], lane, size, wd);
    end else begin
      ld        = m_load(mem_m[idx], lane, size, uns);
      model_res = ld;
      if (lit_en) begin
        @(negedge i_clk);
        chk("literal_load", o_mem_result, lit);
      end
    end
    step();
    drop();
  endtask

  initial begin
    bit          rd;
    bit          wr;
    int          op;
    logic [1:0]  sz;
    logic [31:0] a;
    int          frz;

    i_reset = 1'b1; i_enable = 1'b1; i_mem_rd = 1'b0; i_mem_wr = 1'b0; i_size = 2'b00;
    i_unsigned = 1'b0; i_addr = '0; i_wr_data = '0; i_wb = 1'b0; i_mem_to_reg = 1'b0;
    i_addr_wr = '0;
    exp_stall = 1'b0; exp_mis = 1'b0; model_res = '0;
    step();
    step();
    chk_on = 1'b1;
    step();
    i_reset = 1'b0;
    @(negedge i_clk);
    chk("reset_stall", 32'(o_stall), 32'h0);
    chk("reset_result", o_mem_result, 32'h0);
    step();

    for (int i = 0; i < 256; i++) access(1'b0, 1'b1, 2'b11, 1'b0, 32'(i * 4), $urandom, 0, 0, 0);

    // Reset in the middle of a store: the store is dropped.
    access(1'b0, 1'b1, 2'b11, 1'b0, 32'h10, 32'h0, 0, 0, 0);
    i_mem_rd = 1'b0; i_mem_wr = 1'b1; i_size = 2'b11; i_addr = 32'h10;
    i_wr_data = 32'hDEADBEEF; exp_stall = 1'b1; exp_mis = 1'b0;
    step();
    i_reset = 1'b1;
    step();
    i_reset   = 1'b0;
    model_res = '0;
    drop();
    @(negedge i_clk);
    chk("rst_busy_stall", 32'(o_stall), 32'h0);
    step();
    access(1'b1, 1'b0, 2'b11, 1'b0, 32'h10, 0, 0, 1, 32'h00000000);

    access(1'b0, 1'b1, 2'b11, 1'b0, 32'h20, 32'h12345678, 0, 0, 0);
    access(1'b1, 1'b0, 2'b11, 1'b0, 32'h20, 0, 0, 1, 32'h12345678);

    access(1'b0, 1'b1, 2'b11, 1'b0, 32'h20, 32'h80FF7F01, 0, 0, 0);
    access(1'b1, 1'b0, 2'b00, 1'b0, 32'h23, 0, 0, 1, 32'hFFFFFF80);
    access(1'b1, 1'b0, 2'b00, 1'b1, 32'h23, 0, 0, 1, 32'h00000080);
    access(1'b1, 1'b0, 2'b01, 1'b0, 32'h22, 0, 0, 1, 32'hFFFF80FF);
    access(1'b1, 1'b0, 2'b01, 1'b1, 32'h20, 0, 0, 1, 32'h00007F01);

    access(1'b0, 1'b1, 2'b11, 1'b0, 32'h20, 32'h12345678, 0, 0, 0);
    access(1'b0, 1'b1, 2'b00, 1'b0, 32'h21, 32'h000000AA, 0, 0, 0);
    access(1'b1, 1'b0, 2'b11, 1'b0, 32'h20, 0, 0, 1, 32'h1234AA78);
    access(1'b0, 1'b1, 2'b01, 1'b0, 32'h22, 32'h0000BEEF, 0, 0, 0);
    access(1'b1, 1'b0, 2'b11, 1'b0, 32'h20, 0, 0, 1, 32'hBEEFAA78);

    // Misaligned accesses leave memory untouched.
    access(1'b0, 1'b1, 2'b11, 1'b0, 32'h30, 32'h0BADF00D, 0, 0, 0);
    access(1'b1, 1'b0, 2'b11, 1'b0, 32'h22, 0, 0, 0, 0);
    access(1'b0, 1'b1, 2'b01, 1'b0, 32'h31, 32'h0000FFFF, 0, 0, 0);
    access(1'b1, 1'b0, 2'b11, 1'b0, 32'h30, 0, 0, 1, 32'h0BADF00D);
    access(1'b1, 1'b0, 2'b11, 1'b0, 32'h20, 0, 0, 1, 32'hBEEFAA78);

    // Freeze inside BUSY.
    access(1'b0, 1'b1, 2'b11, 1'b0, 32'h40, 32'hCAFEBABE, 3, 0, 0);
    access(1'b1, 1'b0, 2'b11, 1'b0, 32'h40, 0, 3, 1, 32'hCAFEBABE);

    i_wb = 1'b1; i_mem_to_reg = 1'b1; i_addr_wr = 5'd9;
    @(negedge i_clk);
    chk("pt_wb", 32'(o_wb), 32'h1);
    chk("pt_mem_to_reg", 32'(o_mem_to_reg), 32'h1);
    chk("pt_addr_wr", 32'(o_addr_wr), 32'h9);
    step();

    for (int n = 0; n < 400; n++) begin
      op = int'($urandom_range(0, 3));
      rd = (op == 0) || (op == 2);
      wr = (op == 1) || (op == 2);
      sz = 2'($urandom);
      a  = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'b01)   a[0] = 1'b0;
        else if (sz[1])    a[1:0] = 2'b00;
      end
      frz = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 3)) : 0;
      if ($urandom_range(0, 9) == 0) begin
        rd = 1'b0;
        wr = 1'b0;
      end
      access(rd, wr, sz, 1'($urandom), a, $urandom, frz, 0, 0);
    end

    step();
    step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
